adder_arbiter: RTL

Shares one three-word accumulate datapath among `N_REQ` requesters. A round-robin arbiter grants one requester at a time, then sequences the accumulator through three consecutive input words. It returns the modular sum on `dout` together with a one-cycle `done` pulse addressed to the owner. The block sits between several producer blocks and the shared summing resource, replacing per-producer adders.

---
 rtl/adder_arbiter_pkg.sv | 16 +
 rtl/adder_arbiter_rr_pick.sv | 29 ++
 rtl/adder_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared constants and state encoding for the adder_arbiter block.
package adder_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_N_REQ = 4;
    localparam int unsigned WORDS_PER_TXN = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
        ST_W2   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(N_REQ);

    int unsigned cand;

    // Walk the requesters in priority order starting just after the previous winner
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (int'(last) + i) % N_REQ;
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shared three-word accumulator: grants one requester, sums its
// three consecutive words modulo 2^WIDTH and pulses done to the owner.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEFAULT_N_REQ,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       dout,
    output logic                   busy
);

    localparam int unsigned IW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] word;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Select the current owner's word from the flat data bus
    always_comb begin
        word = din[owner_q*WIDTH +: WIDTH];
    end

    // State, ownership and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state and datapath update: arbitrate in IDLE, then accumulate three words
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ST_W0;
                end
            end
            ST_W0: begin
                acc_d   = word;
                state_d = ST_W1;
            end
            ST_W1: begin
                acc_d   = acc_q + word;
                state_d = ST_W2;
            end
            ST_W2: begin
                dout_d  = acc_q + word;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and owner only; unused encodings drive nothing
    always_comb begin
        gnt  = '0;
        done = '0;
        busy = 1'b0;
        case (state_q)
            ST_W0, ST_W1, ST_W2: begin
                gnt[owner_q] = 1'b1;
                busy         = 1'b1;
            end
            ST_DONE: begin
                done[owner_q] = 1'b1;
                busy          = 1'b1;
            end
            default: begin
                gnt  = '0;
                done = '0;
                busy = 1'b0;
            end
        endcase
    end

    assign dout = dout_q;

endmodule
